// File: rtl/soc_mem_arbiter_if.sv
// Bus bundle between the Ibex instruction/data ports, the arbiter and the shared SRAM.
// The slave modport is the arbiter's view; master is the view of the cores plus the RAM.
interface soc_mem_arbiter_if #(
  parameter int unsigned MEM_WORDS = 8192
);
  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic          i_req;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_addr;
  logic [31:0]   i_rdata;
  logic [6:0]    i_rdata_intg;
  logic          i_err;

  logic          d_req;
  logic          d_gnt;
  logic          d_rvalid;
  logic          d_we;
  logic [3:0]    d_be;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic [6:0]    d_rdata_intg;
  logic          d_err;

  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata, i_rdata_intg, i_err,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_rdata_intg, d_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata, i_rdata_intg, i_err,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_rdata_intg, d_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/soc_mem_arbiter.sv
// Round-robin arbiter sharing one single-port, one-cycle-latency SRAM between the
// Ibex instruction and data ports; out-of-range accesses complete with err.
module soc_mem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 8192
) (
  input logic              clk,
  input logic              rst_n,
  soc_mem_arbiter_if.slave bus
);
  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) << 2;

  logic        grantI;
  logic        grantD;
  logic        anyGnt;
  logic        contended;
  logic        inRange;
  logic [31:0] selAddr;
  logic [31:0] off;

  logic rspValid_q, rspValid_d;
  logic rspOwner_q, rspOwner_d;
  logic rspErr_q, rspErr_d;
  logic lastD_q, lastD_d;

  // Data only wins a tie when instruction did not lose the previous tie.
  always_comb begin
    contended = bus.i_req & bus.d_req;
    grantD    = bus.d_req & (~bus.i_req | ~lastD_q);
    grantI    = bus.i_req & ~grantD;
    anyGnt    = grantI | grantD;
    selAddr   = grantD ? bus.d_addr : bus.i_addr;
    off       = selAddr - BASE_ADDR;
    inRange   = off < MEM_BYTES;
  end

  always_comb begin
    bus.i_gnt     = grantI;
    bus.d_gnt     = grantD;
    bus.mem_req   = anyGnt & inRange;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'h0;
    bus.mem_wdata = 32'h0;
    if (grantD) begin
      bus.mem_addr  = off[AW+1:2];
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_be;
      bus.mem_wdata = bus.d_wdata;
    end else if (grantI) begin
      bus.mem_addr  = off[AW+1:2];
      bus.mem_be    = 4'hF;
    end
  end

  always_comb begin
    rspValid_d = anyGnt;
    rspOwner_d = rspOwner_q;
    rspErr_d   = rspErr_q;
    lastD_d    = lastD_q;
    if (anyGnt) begin
      rspOwner_d = grantD;
      rspErr_d   = ~inRange;
    end
    if (contended) begin
      lastD_d = grantD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspValid_q <= 1'b0;
      rspOwner_q <= 1'b0;
      rspErr_q   <= 1'b0;
      lastD_q    <= 1'b1;
    end else begin
      rspValid_q <= rspValid_d;
      rspOwner_q <= rspOwner_d;
      rspErr_q   <= rspErr_d;
      lastD_q    <= lastD_d;
    end
  end

  // RAM data is forwarded only to the owner of a successful response.
  always_comb begin
    bus.i_rvalid     = rspValid_q & ~rspOwner_q;
    bus.d_rvalid     = rspValid_q & rspOwner_q;
    bus.i_err        = bus.i_rvalid & rspErr_q;
    bus.d_err        = bus.d_rvalid & rspErr_q;
    bus.i_rdata      = (bus.i_rvalid & ~rspErr_q) ? bus.mem_rdata : 32'h0;
    bus.d_rdata      = (bus.d_rvalid & ~rspErr_q) ? bus.mem_rdata : 32'h0;
    bus.i_rdata_intg = 7'h0;
    bus.d_rdata_intg = 7'h0;
  end
endmodule

// File: doc/soc_mem_arbiter.md
# soc_mem_arbiter

Two-port to one-port arbiter that shares a single-port, one-cycle-latency SRAM between the Ibex instruction fetch port and the Ibex data port. It sits between `ibex_top` and the code/data RAM inside `peripherals`, which lets the SoC use one unified memory macro instead of separate instruction and data RAMs. It speaks the Ibex req/gnt/rvalid protocol on both master ports. It resolves contention with round-robin arbitration and flags out-of-range accesses with `err`.

## Interface

Parameters:

- `BASE_ADDR`, default 32'h0000_0000: byte address of RAM word 0.
- `MEM_WORDS`, default 8192: RAM depth in 32-bit words, a power of two. `AW = $clog2(MEM_WORDS)`.

Ports:

- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `i_req` / `i_gnt` / `i_rvalid`, in / out / out, 1 each: instruction port handshake.
- `i_addr`, input, 32: instruction port byte address.
- `i_rdata`, output, 32: instruction port read data.
- `i_rdata_intg`, output, 7: tied to 0.
- `i_err`, output, 1: instruction port error.
- `d_req` / `d_gnt` / `d_rvalid`, in / out / out, 1 each: data port handshake.
- `d_we`, input, 1: data port write enable.
- `d_be`, input, 4: data port byte enables.
- `d_addr`, input, 32: data port byte address.
- `d_wdata`, input, 32: data port write data.
- `d_rdata`, output, 32: data port read data.
- `d_rdata_intg`, output, 7: tied to 0.
- `d_err`, output, 1: data port error.
- `mem_req`, output, 1: RAM access strobe.
- `mem_we`, output, 1: RAM write enable.
- `mem_be`, output, 4: RAM byte enables.
- `mem_addr`, output, AW: RAM word address.
- `mem_wdata`, output, 32: RAM write data.
- `mem_rdata`, input, 32: RAM read data, valid the cycle after `mem_req`.

## Operation

- Grant is combinational and is issued in the same cycle as `req`. At most one of `i_gnt` / `d_gnt` is high in any cycle.
- Single requester: that requester is granted immediately.
- Both requesting: the port that did not win the most recent contended cycle is granted (round robin).
  - `last_d` register: 1 means data won last. It resets to 1, so instruction wins the first tie.
  - `last_d` updates only on contended cycles.
- Range check: `off = addr - BASE_ADDR`. The access is in range iff `off < MEM_WORDS*4`, compared as an unsigned 32-bit value so wrap-around counts as out of range.
- In-range grant:
  - `mem_req` = 1.
  - `mem_addr` = `off[AW+1:2]`.
  - `mem_we`, `mem_be`, `mem_wdata` come from the winning port. For the instruction port they are 0, 4'hF and 0.
- Out-of-range grant: granted normally, with `mem_req` = 0. The port receives `rvalid` = 1, `err` = 1 and `rdata` = 0 one cycle later.
- Response pipeline registers: `rsp_valid`, `rsp_owner` (0 = instruction, 1 = data), `rsp_err`. All are loaded on every cycle where a grant occurs.
- Response outputs:
  - `x_rvalid` = `rsp_valid & (rsp_owner == x)`.
  - `x_rdata` = `mem_rdata` when `x_rvalid & ~rsp_err`, else 0.
  - `x_err` = `x_rvalid & rsp_err`.
- Writes also return `rvalid`, with `rdata` = 0, as Ibex requires.
- Address bits [1:0] are ignored. Ibex issues only word-aligned addresses with byte enables.
- Ports without a request have `gnt` = 0. Inputs from an ungranted port never reach the memory.

## Timing

- Every response has latency 1: the cycle after the grant.
- Back-to-back grants are fully pipelined, giving one access per cycle of throughput.
- Under continuous dual contention each port gets 50 % of accesses and grants strictly alternate.
- Maximum wait for any requester is 1 cycle.
- Reset values: `rsp_valid` = 0, `rsp_owner` = 0, `rsp_err` = 0, `last_d` = 1.
  - Hence all `rvalid`, `err` and `rdata` outputs are 0 during and after reset until a grant occurs.
- `gnt` and `mem_*` are combinational from the request inputs.
- Reset asserted with a response pending: the response is dropped and no `rvalid` is issued.
- Simultaneous grant in cycle N and response in cycle N+1 to a different port is legal. The response registers are overwritten each granted cycle and never stall.

## Test plan

- **Single instruction fetch.** `i_req`=1 with `i_addr`=0x100 and RAM word 0x40 = 0xDEADBEEF. Expect `i_gnt`=1 the same cycle, `mem_addr`=0x40. The next cycle gives `i_rvalid`=1, `i_rdata`=0xDEADBEEF, `d_rvalid`=0.
- **Data write with byte enables.** `d_we`=1, `d_be`=4'b0011, `d_addr`=0x8, `d_wdata`=0x12345678. Expect `mem_we`=1, `mem_be`=0011, `mem_addr`=2. Next cycle `d_rvalid`=1 and `d_err`=0. A read-back of that word returns 0x????5678, with the upper half unchanged.
- **Contention after reset.** Hold both `i_req` and `d_req` for 4 cycles. Expect grants in the order I, D, I, D, with responses one cycle after each grant to the matching port.
- **Out of range.** With MEM_WORDS=8192, `d_addr`=0x8000: `d_gnt`=1 and `mem_req`=0. Next cycle `d_rvalid`=1, `d_err`=1, `d_rdata`=0.
  - The same applies with BASE_ADDR=0x1000 and `d_addr`=0x0FFC (subtraction wrap).
- **Reset mid-operation.** Grant a read, then assert `rst_n`=0 asynchronously before the next edge. Expect no `rvalid` on either port. After release, the first tie is won by instruction.
- **Pipelined mixed traffic.** Issue `d_req` in cycle 0 and `i_req` alone in cycle 1. Expect `d_rvalid` in cycle 1 and `i_rvalid` in cycle 2, each with its own correct data.
